// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared state encoding, error indices and default timing for the IR receiver
package ir_pkg;

   typedef enum logic [1:0] {
      DEC_RESET = 2'd0,
      LISTEN    = 2'd1,
      CHECK     = 2'd2,
      PUSH      = 2'd3
   } ir_state_t;

   localparam logic [3:0] DEC_IDLE = 4'd0;

   localparam int ERR_OVERFLOW = 0;
   localparam int ERR_WATCHDOG = 1;
   localparam int ERR_CHECK    = 2;

   localparam int DEF_HOLDOFF_CYCLES  = 10_000_000;
   localparam int DEF_WATCHDOG_CYCLES = 2_000_000;

endpackage

// File: rtl/ir_code_fifo.sv
// rtl/ir_code_fifo.sv - show-ahead code FIFO; a push on full succeeds only alongside a pop
module ir_code_fifo #(
   parameter int MESSAGE_LENGTH = 32,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        push,
   input  logic [MESSAGE_LENGTH-1:0]   push_data,
   input  logic                        pop,
   output logic [MESSAGE_LENGTH-1:0]   head,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   DEPTH_C = FIFO_DEPTH[PW:0];
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [PW:0]   CNT_ONE = 1;

   logic [MESSAGE_LENGTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr_q;
   logic [PW-1:0]             rd_ptr_q;
   logic [PW:0]               count_q;
   logic                      pop_ok;
   logic                      push_ok;

   assign full    = (count_q == DEPTH_C);
   assign pop_ok  = pop && (count_q != '0);
   assign push_ok = push && (!full || pop_ok);
   assign count   = count_q;
   assign head    = (count_q != '0) ? mem[rd_ptr_q] : '0;

   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   // Pointer width equals log2(depth), so increments wrap modulo depth for free.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push_ok && !pop_ok)      count_q <= count_q + CNT_ONE;
         else if (!push_ok && pop_ok) count_q <= count_q - CNT_ONE;
      end
   end

endmodule

// File: rtl/ir_rx_controller.sv
// rtl/ir_rx_controller.sv - IR decoder supervisor: validates, de-duplicates and buffers received codes
module ir_rx_controller
   import ir_pkg::*;
#(
   parameter int MESSAGE_LENGTH  = 32,
   parameter int FIFO_DEPTH      = 4,
   parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
   parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES,
   parameter bit CHECK_EN        = 1'b1
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        enable_in,
   input  logic [MESSAGE_LENGTH-1:0]   dec_code_in,
   input  logic                        dec_new_code_in,
   input  logic [3:0]                  dec_state_in,
   output logic                        dec_rst_out,
   output logic [MESSAGE_LENGTH-1:0]   code_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
   output logic [2:0]                  error_out,
   input  logic                        clear_err_in
);

   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HOLDOFF_CYCLES[HW-1:0];
   localparam logic [HW-1:0] HOLD_ONE  = 1;
   localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);
   localparam logic [WW-1:0] WD_ONE    = 1;

   ir_state_t                 state_q, state_d;
   logic [1:0]                sync_q;
   logic                      rst_seen_q;
   logic [MESSAGE_LENGTH-1:0] cap_q;
   logic [MESSAGE_LENGTH-1:0] last_q;
   logic [HW-1:0]             holdoff_q;
   logic [WW-1:0]             wd_q;
   logic [2:0]                err_q;
   logic                      fifo_push, fifo_pop, fifo_full, push_acc;
   logic                      check_fail, dup_hit, wd_hit;
   logic [2:0]                err_evt;

   ir_code_fifo #(
      .MESSAGE_LENGTH (MESSAGE_LENGTH),
      .FIFO_DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push      (fifo_push),
      .push_data (cap_q),
      .pop       (fifo_pop),
      .head      (code_out),
      .full      (fifo_full),
      .count     (fifo_count_out)
   );

   assign valid_out   = (fifo_count_out != '0);
   assign fifo_pop    = valid_out && ready_in;
   assign push_acc    = fifo_push && (!fifo_full || fifo_pop);
   assign dec_rst_out = (state_q == DEC_RESET);
   assign error_out   = err_q;

   always_comb begin
      err_evt               = '0;
      err_evt[ERR_OVERFLOW] = fifo_push && !push_acc;
      err_evt[ERR_WATCHDOG] = wd_hit;
      err_evt[ERR_CHECK]    = check_fail;
   end

   // Reset is asserted asynchronously but released through two flops before the FSM may leave DEC_RESET.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) sync_q <= 2'b00;
      else           sync_q <= {sync_q[0], 1'b1};
   end

   always_comb begin
      state_d    = state_q;
      check_fail = 1'b0;
      dup_hit    = 1'b0;
      wd_hit     = 1'b0;
      fifo_push  = 1'b0;
      case (state_q)
         DEC_RESET: if (rst_seen_q && sync_q[1]) state_d = LISTEN;
         LISTEN: begin
            if (dec_state_in != DEC_IDLE && wd_q == WD_LAST) begin
               wd_hit  = 1'b1;
               state_d = DEC_RESET;
            end else if (dec_new_code_in) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (CHECK_EN && cap_q[15:8] != ~cap_q[7:0]) begin
               check_fail = 1'b1;
               state_d    = LISTEN;
            end else if (cap_q == last_q && holdoff_q != '0) begin
               dup_hit = 1'b1;
               state_d = LISTEN;
            end else begin
               state_d = PUSH;
            end
         end
         PUSH: begin
            fifo_push = 1'b1;
            state_d   = LISTEN;
         end
         default: state_d = DEC_RESET;
      endcase
      // Disabling abandons whatever code is in flight; buffered codes stay.
      if (!enable_in) begin
         state_d    = DEC_RESET;
         check_fail = 1'b0;
         dup_hit    = 1'b0;
         wd_hit     = 1'b0;
         fifo_push  = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= DEC_RESET;
         rst_seen_q <= 1'b0;
         cap_q      <= '0;
         last_q     <= '0;
         holdoff_q  <= '0;
         wd_q       <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         rst_seen_q <= (state_q == DEC_RESET);
         if (state_q == LISTEN && state_d == CHECK) cap_q <= dec_code_in;
         if (push_acc) last_q <= cap_q;
         if (push_acc || dup_hit)  holdoff_q <= HOLD_LOAD;
         else if (holdoff_q != '0) holdoff_q <= holdoff_q - HOLD_ONE;
         if (state_q == LISTEN && dec_state_in != DEC_IDLE && !wd_hit) wd_q <= wd_q + WD_ONE;
         else                                                           wd_q <= '0;
         err_q <= (clear_err_in ? 3'b000 : err_q) | err_evt;
      end
   end

endmodule

// File: tb/tb_ir_rx_controller.sv
// tb/tb_ir_rx_controller.sv - directed, table-driven bench for ir_rx_controller
module tb_ir_rx_controller;

   localparam int ML = 32;
   localparam int FD = 4;
   localparam int HOLD = 200;
   localparam int WD = 50;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          enable_in = 1'b0;
   logic [ML-1:0] dec_code_in = '0;
   logic          dec_new_code_in = 1'b0;
   logic [3:0]    dec_state_in = 4'd0;
   logic          dec_rst_out;
   logic [ML-1:0] code_out;
   logic          valid_out;
   logic          ready_in = 1'b0;
   logic [2:0]    fifo_count_out;
   logic [2:0]    error_out;
   logic          clear_err_in = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] code;
      int          gap;
      bit          push;
      logic [2:0]  err;
   } vec_t;

   vec_t        tbl [7];
   logic [31:0] ovf_codes [5];

   ir_rx_controller #(
      .MESSAGE_LENGTH  (ML),
      .FIFO_DEPTH      (FD),
      .HOLDOFF_CYCLES  (HOLD),
      .WATCHDOG_CYCLES (WD),
      .CHECK_EN        (1'b1)
   ) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .enable_in       (enable_in),
      .dec_code_in     (dec_code_in),
      .dec_new_code_in (dec_new_code_in),
      .dec_state_in    (dec_state_in),
      .dec_rst_out     (dec_rst_out),
      .code_out        (code_out),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .fifo_count_out  (fifo_count_out),
      .error_out       (error_out),
      .clear_err_in    (clear_err_in)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic [31:0] c);
      dec_code_in     = c;
      dec_new_code_in = 1'b1;
      tick();
      dec_new_code_in = 1'b0;
   endtask

   task automatic wait_listen(input string name);
      for (int k = 0; k < 20 && dec_rst_out; k++) tick();
      check(name, 32'(dec_rst_out), 32'd0);
   endtask

   task automatic clear_errors();
      clear_err_in = 1'b1;
      tick();
      clear_err_in = 1'b0;
   endtask

   initial begin
      int n;
      int hi;

      tbl[0] = '{32'h00FF38C8, 5,   1'b0, 3'b100};
      tbl[1] = '{32'h00FF30CF, 5,   1'b1, 3'b000};
      tbl[2] = '{32'h00FF30CF, 20,  1'b0, 3'b000};
      tbl[3] = '{32'h00FF30CF, 300, 1'b1, 3'b000};
      tbl[4] = '{32'h12345AA5, 5,   1'b1, 3'b000};
      tbl[5] = '{32'h00FF00FF, 5,   1'b1, 3'b000};
      tbl[6] = '{32'h00FF0000, 5,   1'b0, 3'b100};
      ovf_codes = '{32'h000001FE, 32'h000002FD, 32'h000003FC, 32'h000004FB, 32'h000005FA};

      repeat (3) tick();
      check("rst dec_rst", 32'(dec_rst_out), 32'd1);
      check("rst valid", 32'(valid_out), 32'd0);
      check("rst code", code_out, 32'd0);
      check("rst count", 32'(fifo_count_out), 32'd0);
      check("rst err", 32'(error_out), 32'd0);
      rst_n_in  = 1'b1;
      enable_in = 1'b1;
      tick();
      check("post-release dec_rst", 32'(dec_rst_out), 32'd1);
      wait_listen("first listen");

      strobe(32'h00FF38C7);
      check("lat T+1 valid", 32'(valid_out), 32'd0);
      tick();
      check("lat T+2 valid", 32'(valid_out), 32'd0);
      tick();
      check("lat T+3 valid", 32'(valid_out), 32'd1);
      check("lat code", code_out, 32'h00FF38C7);
      check("lat err", 32'(error_out), 32'd0);
      ready_in = 1'b1;
      tick();
      check("lat pop count", 32'(fifo_count_out), 32'd0);

      for (int i = 0; i < 7; i++) begin
         repeat (tbl[i].gap) tick();
         strobe(tbl[i].code);
         tick();
         tick();
         check($sformatf("vec%0d valid", i), 32'(valid_out), 32'(tbl[i].push));
         check($sformatf("vec%0d count", i), 32'(fifo_count_out), 32'(tbl[i].push));
         if (tbl[i].push) check($sformatf("vec%0d code", i), code_out, tbl[i].code);
         check($sformatf("vec%0d err", i), 32'(error_out), 32'(tbl[i].err));
         clear_errors();
      end

      ready_in = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         strobe(ovf_codes[i]);
         repeat (3) tick();
      end
      check("ovf count", 32'(fifo_count_out), 32'd4);
      check("ovf err", 32'(error_out), 32'b001);
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf pop%0d code", i), code_out, ovf_codes[i]);
         tick();
      end
      check("ovf drained", 32'(fifo_count_out), 32'd0);
      ready_in = 1'b0;
      clear_errors();

      dec_state_in = 4'd3;
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (error_out[1]) begin
            n = k;
            break;
         end
      end
      check("wd cycles", 32'(n), 32'(WD));
      check("wd err", 32'(error_out), 32'b010);
      dec_state_in = 4'd0;
      hi = 0;
      for (int k = 0; k < 20 && dec_rst_out; k++) begin
         hi++;
         tick();
      end
      check("wd rst pulse >= 2", 32'(hi >= 2), 32'd1);
      check("wd back to listen", 32'(dec_rst_out), 32'd0);
      clear_errors();
      check("clear err", 32'(error_out), 32'd0);

      strobe(32'h000007F8);
      tick();
      tick();
      check("dis pre count", 32'(fifo_count_out), 32'd1);
      strobe(32'h000006F9);
      enable_in = 1'b0;
      repeat (3) tick();
      check("dis dec_rst", 32'(dec_rst_out), 32'd1);
      check("dis count kept", 32'(fifo_count_out), 32'd1);
      check("dis head kept", code_out, 32'h000007F8);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      check("dis pop", 32'(fifo_count_out), 32'd0);
      enable_in = 1'b1;
      tick();
      wait_listen("re-enable listen");

      strobe(32'h00FF38C8);
      tick();
      check("pre-rst err", 32'(error_out), 32'b100);
      strobe(32'h000009F6);
      tick();
      tick();
      check("pre-rst count", 32'(fifo_count_out), 32'd1);
      strobe(32'h000008F7);
      tick();
      rst_n_in = 1'b0;
      #1;
      check("midpush dec_rst", 32'(dec_rst_out), 32'd1);
      check("midpush valid", 32'(valid_out), 32'd0);
      check("midpush code", code_out, 32'd0);
      check("midpush count", 32'(fifo_count_out), 32'd0);
      check("midpush err", 32'(error_out), 32'd0);
      repeat (2) tick();
      rst_n_in = 1'b1;
      tick();
      wait_listen("post-rst listen");
      check("post-rst count", 32'(fifo_count_out), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_rx_controller.md
IR_RX_CONTROLLER -- requirements
Module: ir_rx_controller

Interface
REQ-001 Parameter MESSAGE_LENGTH, default 32, SHALL set the width of decoder codes and of stored codes.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two, SHALL set the number of buffered codes.
REQ-003 Parameter HOLDOFF_CYCLES, default 10_000_000, SHALL set the duplicate-suppression window (100 ms at 100 MHz).
REQ-004 Parameter WATCHDOG_CYCLES, default 2_000_000, SHALL set the maximum time the decoder may stay out of IDLE.
REQ-005 Parameter CHECK_EN, default 1, SHALL enable the command-complement check.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 Ports SHALL be:
 clk_in  input  1  system clock, 100 MHz
 rst_n_in  input  1  asynchronous active-low reset
 enable_in  input  1  receive enable
 dec_code_in  input  MESSAGE_LENGTH  decoder code
 dec_new_code_in  input  1  decoder single-cycle new-code strobe
 dec_state_in  input  4  decoder state, 0 = IDLE
 dec_rst_out  output  1  active-high synchronous reset to decoder
 code_out  output  MESSAGE_LENGTH  head-of-FIFO code
 valid_out  output  1  code_out valid
 ready_in  input  1  consumer accepts; pop when valid_out & ready_in
 fifo_count_out  output  $clog2(FIFO_DEPTH)+1  stored codes
 error_out  output  3  sticky: [0] overflow, [1] watchdog, [2] check fail
 clear_err_in  input  1  clears error_out

Function
REQ-008 The FSM SHALL have states DEC_RESET, LISTEN, CHECK and PUSH.
REQ-009 DEC_RESET SHALL drive dec_rst_out=1 for at least 2 cycles and SHALL stay there while enable_in=0; it then moves to LISTEN with dec_rst_out=0.
REQ-010 enable_in=0 in any state SHALL force DEC_RESET next cycle and discard any in-flight code; FIFO contents are retained and remain poppable.
REQ-011 In LISTEN, dec_new_code_in=1 SHALL latch dec_code_in into a capture register and go to CHECK; strobes in other states SHALL be ignored.
REQ-012 CHECK, with CHECK_EN=1, SHALL fail when code[15:8] != ~code[7:0]; failure sets error_out[2] and returns to LISTEN.
REQ-013 CHECK SHALL drop the code, reload the holdoff counter and return to LISTEN when it equals the last accepted code and the holdoff counter is nonzero; otherwise it SHALL go to PUSH.
REQ-014 PUSH SHALL write the code into the FIFO, store it as last accepted, load holdoff to HOLDOFF_CYCLES and return to LISTEN.
REQ-015 PUSH on a full FIFO SHALL drop the code and set error_out[0], unless a pop occurs that same cycle, in which case the write SHALL succeed.
REQ-016 Latency: strobe in cycle T -> CHECK T+1 -> PUSH T+2 -> valid_out=1 at T+3 when the FIFO was empty.
REQ-017 The FIFO SHALL be show-ahead: code_out is the oldest entry whenever valid_out=1, and it is held stable until popped.
REQ-018 valid_out SHALL equal (fifo_count_out != 0); pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The holdoff counter SHALL decrement by one per cycle to 0 and saturate there.
REQ-020 In LISTEN, the watchdog SHALL count cycles with dec_state_in != 0 and clear when it equals 0.
REQ-021 When the watchdog reaches WATCHDOG_CYCLES, the block SHALL set error_out[1] and go to DEC_RESET.
REQ-022 clear_err_in SHALL zero error_out next cycle; an error event in the same cycle SHALL win for its bit.

Reset
REQ-023 rst_n_in=0 SHALL asynchronously force state DEC_RESET, dec_rst_out=1, valid_out=0, code_out=0, fifo_count_out=0, error_out=0, and all counters, pointers and last-code registers to 0.
REQ-024 Release of reset SHALL be synchronised internally; the first cycle after release is DEC_RESET.

Structure
REQ-025 Package ir_pkg SHALL hold the controller state enum, decoder IDLE encoding constant (0), error-bit index constants and default timing constants.
REQ-026 The FIFO SHALL be a sub-module ir_code_fifo (parameters MESSAGE_LENGTH, FIFO_DEPTH; push/pop/full/count ports).

Verification
REQ-027 Reset release, enable_in=1, strobe with code 0x00FF38C7 -> valid_out=1 exactly 3 cycles after the strobe, code_out=0x00FF38C7, error_out=0.
REQ-028 Strobe 0x00FF38C8 -> no push, error_out=3'b100, fifo_count_out=0.
REQ-029 Same valid code twice 1 ms apart -> one entry. Third copy 150 ms after the second -> second entry.
REQ-030 ready_in=0, five distinct valid codes -> fifo_count_out=4, error_out[0]=1. Then ready_in=1 -> the first four codes pop in order.
REQ-031 dec_state_in held at 3 for WATCHDOG_CYCLES -> error_out[1]=1 and a dec_rst_out pulse of at least 2 cycles. clear_err_in -> error_out=0.
REQ-032 rst_n_in asserted mid-PUSH -> outputs reach reset values immediately, with no FIFO entry written.
